// File: rtl/div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_sequencer                                              |
// | Description : Multi-cycle unsigned restoring divider with HI/LO result   |
// |               registers, pipeline stall generation and mfhi/mflo read.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             mf_req,
   input  logic             mf_sel,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dbz_q, dbz_d;

   // One restoring step: the shifted partial remainder is WIDTH+1 bits so the
   // borrow out of the trial subtraction tells us whether the divisor fits.
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_quo;

   assign w_shifted  = {rem_q, quo_q[WIDTH-1]};
   assign w_trial    = w_shifted - {1'b0, dvs_q};
   assign w_step_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_step_quo = {quo_q[WIDTH-2:0], ~w_trial[WIDTH]};

   // Next-state and datapath update: start acceptance, iteration and completion.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (div_start) begin
               if (divisor != '0) begin
                  dvs_d   = divisor;
                  quo_d   = dividend;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  // Divide by zero finishes immediately with a defined result.
                  hi_d    = dividend;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            rem_d = w_step_rem;
            quo_d = w_step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               hi_d    = w_step_rem;
               lo_d    = w_step_quo;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any division in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   // Status outputs are forced low while reset is asserted.
   assign busy        = ~rst & (state_q == S_RUN);
   assign done        = ~rst & (state_q == S_DONE);
   assign div_by_zero = done & dbz_q;
   assign stall       = busy & (mf_req | div_start);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign mf_data     = mf_sel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div_sequencer                                           |
// | Description : Self-checking bench for div_sequencer with directed and    |
// |               randomized divisions against an arithmetic reference.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_div_sequencer;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        mf_req;
   logic        mf_sel;
   logic        stall;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_data;

   int          n_checks;
   int          n_errors;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   div_sequencer #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .div_start   (div_start),
      .dividend    (dividend),
      .divisor     (divisor),
      .mf_req      (mf_req),
      .mf_sel      (mf_sel),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo),
      .mf_data     (mf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Waits for completion of a division whose start was accepted in the
   // previous cycle; called just after the accepting edge.
   task automatic finish_div(input logic [31:0] a, input logic [31:0] b, input string tag);
      int          n;
      int          nbusy;
      bit          seen;
      bit          hold_ok;
      logic [31:0] eq;
      logic [31:0] er;
      eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
      er = (b == 0) ? a : a % b;
      dividend = $urandom;
      divisor  = $urandom;
      n = 0; nbusy = 0; seen = 0; hold_ok = 1;
      while (!seen && n < 40) begin
         n++;
         @(negedge clk);
         if (busy) nbusy++;
         if (done) seen = 1;
         else begin
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 0;
            @(posedge clk); #1;
         end
      end
      check({tag, " latency"}, n, (b == 0) ? 1 : 33);
      check({tag, " busy cycles"}, nbusy, (b == 0) ? 0 : 32);
      check({tag, " hilo held"}, {31'd0, hold_ok}, 32'd1);
      check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 0)});
      check({tag, " hi"}, hi, er);
      check({tag, " lo"}, lo, eq);
      mf_sel = 1'b1; #1;
      check({tag, " mf hi"}, mf_data, er);
      mf_sel = 1'b0; #1;
      check({tag, " mf lo"}, mf_data, eq);
      exp_hi = er;
      exp_lo = eq;
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " done width"}, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
      div_start = 1'b1;
      dividend  = a;
      divisor   = b;
      @(negedge clk);
      check({tag, " idle stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      div_start = 1'b0;
      finish_div(a, b, tag);
   endtask

   initial begin
      int          nst;
      int          ndone;
      logic [31:0] a;
      logic [31:0] b;
      n_checks = 0; n_errors = 0;
      rst = 1'b1; div_start = 1'b1; dividend = 32'd5; divisor = 32'd0;
      mf_req = 1'b1; mf_sel = 1'b0;
      exp_hi = '0; exp_lo = '0;

      // Reset state: outputs quiet while reset is high despite active inputs.
      @(posedge clk); #1;
      @(negedge clk);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst stall", {31'd0, stall}, 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; div_start = 1'b0; mf_req = 1'b0;
      @(posedge clk); #1;

      run_div(32'd100, 32'd7, "100/7");
      run_div(32'h0000_1234, 32'd0, "1234/0");

      // Stall on mfhi during a long division, released in the DONE cycle.
      div_start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
      @(posedge clk); #1;
      div_start = 1'b0;
      nst = 0;
      for (int k = 1; k <= 32; k++) begin
         if (k == 5) begin mf_req = 1'b1; mf_sel = 1'b1; end
         @(negedge clk);
         if (stall) nst++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("mf stall cycles", nst, 32'd28);
      check("mf done", {31'd0, done}, 32'd1);
      check("mf done stall", {31'd0, stall}, 32'd0);
      check("mf hi new", mf_data, 32'd0);
      mf_sel = 1'b0; #1;
      check("mf lo new", mf_data, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      mf_req = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'hFFFF_FFFF;
      @(posedge clk); #1;

      // Second start held during RUN, accepted in the DONE cycle.
      div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); #1;
      dividend = 32'd50; divisor = 32'd5;
      nst = 0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (stall) nst++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("b2b stall cycles", nst, 32'd32);
      check("b2b first done", {31'd0, done}, 32'd1);
      check("b2b done stall", {31'd0, stall}, 32'd0);
      check("b2b first lo", lo, 32'd333);
      check("b2b first hi", hi, 32'd1);
      exp_hi = 32'd1; exp_lo = 32'd333;
      @(posedge clk); #1;
      div_start = 1'b0;
      finish_div(32'd50, 32'd5, "b2b 50/5");

      // Reset mid-run discards the division.
      run_div(32'd19, 32'd4, "19/4");
      check("prior hi", hi, 32'd3);
      check("prior lo", lo, 32'd4);
      div_start = 1'b1; dividend = 32'd9; divisor = 32'd2;
      @(posedge clk); #1;
      div_start = 1'b0;
      for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
      rst = 1'b1; mf_req = 1'b1;
      @(negedge clk);
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mf_req = 1'b0;
      @(negedge clk);
      check("postrst busy", {31'd0, busy}, 32'd0);
      check("postrst hi", hi, 32'd0);
      check("postrst lo", lo, 32'd0);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("postrst no done", ndone, 32'd0);
      @(posedge clk); #1;
      exp_hi = 32'd0; exp_lo = 32'd0;

      // mf read coinciding with a start in IDLE returns the old HI.
      run_div(32'd7, 32'd10, "7/10");
      div_start = 1'b1; mf_req = 1'b1; mf_sel = 1'b1;
      dividend = 32'd100; divisor = 32'd3;
      @(negedge clk);
      check("idle mf data", mf_data, 32'd7);
      check("idle mf stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      div_start = 1'b0; mf_req = 1'b0;
      finish_div(32'd100, 32'd3, "100/3");

      // Randomized operands, including zero and small divisors.
      for (int it = 0; it < 20; it++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 16);
            2:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_div(a, b, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, quotient, remainder and HI/LO width; only 32 is supported.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port div_start, input, 1 bit, SHALL request a division; it is driven from the EX-stage "to divd" control bit.
REQ-005 Ports dividend and divisor, inputs, WIDTH bits each, SHALL be unsigned operands (rs, rt), sampled only when a start is accepted.
REQ-006 Port mf_req, input, 1 bit, SHALL request a read for an mfhi/mflo in EX.
REQ-007 Port mf_sel, input, 1 bit, SHALL select HI when 1 and LO when 0.
REQ-008 Port stall, output, 1 bit, SHALL freeze IF/ID/EX when high.
REQ-009 Port busy, output, 1 bit, SHALL be high while in state RUN.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-011 Port div_by_zero, output, 1 bit, SHALL be valid only with done; high means the divisor was 0.
REQ-012 Ports hi and lo, outputs, WIDTH bits each, SHALL be the architectural HI (remainder) and LO (quotient) registers.
REQ-013 Port mf_data, output, WIDTH bits, SHALL equal mf_sel ? hi : lo, combinationally.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 A start SHALL be accepted when div_start=1 and the state is IDLE or DONE.
- Divisor != 0: latch operands, clear remainder and count to 0, next state RUN.
- Divisor == 0: next state DONE; hi<=dividend, lo<=all-ones, div_by_zero flag set.
REQ-016 Each RUN cycle SHALL perform one restoring step:
- Shift {rem,quo} left 1.
- Trial = rem - divisor, computed WIDTH+1 bits wide.
- If the trial is non-negative, rem<=trial and quo LSB<=1; else quo LSB<=0.
- count increments by 1.
REQ-017 When count==WIDTH-1 the final step SHALL complete: hi<=rem, lo<=quo, div_by_zero flag cleared, next state DONE.
REQ-018 Latency: with div_start in cycle c and divisor != 0, busy SHALL be high in cycles c+1..c+32 and done high in cycle c+33, with hi/lo updated from cycle c+33.
REQ-019 Divide-by-zero latency: done SHALL be high in cycle c+1.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE, or to RUN/DONE if a new start is accepted in that cycle.
REQ-021 The stall equation SHALL be stall = busy & (mf_req | div_start). Other instructions never stall.
REQ-022 div_start arriving during RUN SHALL be held off by stall and accepted in the DONE cycle; operands are sampled then.
REQ-023 mf_req in the DONE cycle SHALL NOT stall and SHALL return the new result.
REQ-024 When mf_req and div_start coincide in IDLE, mf_data SHALL return the pre-division HI/LO value.
REQ-025 hi and lo SHALL change only at division completion or reset.
REQ-026 All arithmetic SHALL be unsigned, with no overflow state.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE and clear hi, lo, remainder, quotient and count to 0.
REQ-028 While rst=1, busy, done, div_by_zero and stall SHALL be 0.
REQ-029 rst SHALL take priority over every other input, including mid-RUN; any in-flight division is discarded and produces no done.

Verification
REQ-030 100/7, start in cycle c -> busy c+1..c+32; done at c+33; lo=14, hi=2, div_by_zero=0.
REQ-031 0x00001234/0 -> done at c+1; hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1; busy never high.
REQ-032 0xFFFFFFFF/1, then mf_req=1 mf_sel=1 held from c+5 -> stall high c+5..c+32; in c+33 stall=0, mf_data=0; with mf_sel=0, mf_data=0xFFFFFFFF.
REQ-033 Second div_start (50/5) held high during the first division's RUN -> stall high until DONE; accepted in the DONE cycle; second done 33 cycles later with lo=10, hi=0.
REQ-034 Prior hi=3, lo=4; start 9/2; rst in cycle c+10 -> cycle c+11: busy=0, hi=0, lo=0; no done pulse ever appears.
REQ-035 IDLE with hi=7, div_start plus mf_req (mf_sel=1) in the same cycle -> mf_data=7, stall=0 that cycle.
